mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port of the multicycle MIPS core between two requesters: the CPU (port C) and a DMA/loader engine (port D).
- Performs at most one memory access per cycle. The CPU has default priority; DMA is protected by an anti-starvation counter and a burst lock.
- Sits between the core's adr/writedata/memwrite/readdata and a synchronous single-port RAM with 1-cycle read latency.
- Produces cpu_stall, which the core uses to hold its FSM state.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_BURST, 8, max consecutive DMA grants while the CPU is waiting (>=1)
STARVE_LIMIT, 4, consecutive denied DMA cycles before DMA wins a contested cycle (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
cpu_req  in  1  CPU access request; held until not stalled
cpu_we  in  1  1 = write, 0 = read
cpu_adr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_stall  out  1  cpu_req & ~cpu_gnt (combinational)
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  DW  CPU read data
dma_req  in  1  DMA request; req/we/adr/wdata held stable until dma_gnt
dma_we  in  1  1 = write
dma_adr  in  AW  DMA address
dma_wdata  in  DW  DMA write data
dma_gnt  out  1  DMA access issued this cycle (combinational)
dma_rvalid  out  1  DMA read data valid
dma_rdata  out  DW  DMA read data
mem_en  out  1  RAM access this cycle
mem_we  out  1  RAM write enable
mem_adr  out  AW  RAM address
mem_wdata  out  DW  RAM write data
mem_rdata  in  DW  RAM read data, valid the cycle after a read issue

Behaviour:
- **State register** (reset -> IDLE):
  - states IDLE, CPU_OWN, DMA_OWN record the owner of the previous cycle's grant.
  - next = CPU_OWN on cpu_gnt, DMA_OWN on dma_gnt, else IDLE.
- **Counters:**
  - burst_cnt: +1 on each dma_gnt, cleared on any cycle without dma_gnt, saturates at MAX_BURST.
  - starve_cnt: +1 when dma_req & ~dma_gnt, cleared on dma_gnt, saturates at STARVE_LIMIT.
  - Widths are $clog2(LIMIT+1). Both reset to 0.
- **Grant (combinational, same cycle as request):**
  - neither requests: no grant.
  - only one requests: grant it.
  - both request:
    - DMA wins if (state==DMA_OWN and burst_cnt<MAX_BURST) or starve_cnt==STARVE_LIMIT.
    - otherwise CPU wins.
- **Memory drive:**
  - mem_en = cpu_gnt|dma_gnt.
  - mem_we = granted requester's we & mem_en.
  - mem_adr/mem_wdata come from the granted requester; CPU fields are driven when idle.
- **Read return:**
  - On a granted read, rd_pending<=1 and rd_owner<=requester; otherwise rd_pending<=0.
  - Next cycle: cpu_rvalid = rd_pending & rd_owner==C; dma_rvalid likewise for D.
  - cpu_rdata = dma_rdata = mem_rdata (pass-through).
  - Latency is exactly 1 cycle after grant.
  - Writes never produce rvalid.
- **Back-to-back:** a grant is allowed every cycle, including a new grant in the same cycle an earlier read returns.
- **Reset asserted:**
  - dma_gnt=0, mem_en=0, mem_we=0, cpu_rvalid=0, dma_rvalid=0.
  - cpu_stall = cpu_req; state IDLE; counters 0.
- **Reset mid-operation:**
  - in-flight read is discarded; no rvalid after release.
  - first grant is possible in the first clock edge's cycle after release.
- **Simultaneous events:** when DMA wins via the starvation path, burst_cnt becomes 1 and the burst lock then holds DMA for up to MAX_BURST total beats while it keeps requesting.
- **Burst end:** DMA deasserting dma_req ends the burst immediately (burst_cnt clears).

Decomposition:
- Package mem_arb_pkg:
  - state encoding constants IDLE=2'b00, CPU_OWN=2'b01, DMA_OWN=2'b10
  - owner ID constants OWN_CPU=1'b0, OWN_DMA=1'b1
- One natural sub-module: sat_counter (parameterised LIMIT, inc/clr, async active-low reset), instantiated twice for burst_cnt and starve_cnt.

Test Plan:
1. Reset hold, cpu_req=1: reset=0 -> mem_en=0, cpu_stall=1, rvalids 0. Release reset -> cpu_gnt in the first cycle, mem_en=1.
2. CPU read adr=0x40, RAM returns 0xDEADBEEF -> cycle0 mem_en=1, mem_we=0, mem_adr=0x40, cpu_stall=0; cycle1 cpu_rvalid=1, cpu_rdata=0xDEADBEEF, dma_rvalid=0.
3. DMA write alone, adr=0x100, wdata=0x12345678 -> dma_gnt=1 same cycle, mem_we=1, mem_wdata=0x12345678; no rvalid next cycle.
4. Both request continuously from IDLE (defaults):
   - CPU granted cycles 0-3.
   - DMA granted cycles 4-11 (8 beats); cpu_stall=1 for cycles 4-11.
   - CPU granted cycle 12; pattern repeats.
5. Alternating reads: CPU read 0x10 (cycle0), DMA read 0x20 (cycle1) -> cycle1 cpu_rvalid only; cycle2 dma_rvalid only, with data matching each address.
6. CPU read granted cycle N, reset asserted in cycle N+1 before the edge -> cpu_rvalid stays 0; after release state is IDLE and starve_cnt=0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// mem_arb_pkg : shared encodings for the CPU/DMA memory port arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  // Owner of the previous cycle's grant
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CPU_OWN = 2'b01,
    DMA_OWN = 2'b10
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// mem_port_arbiter_if : CPU, DMA and RAM side bundle of the memory arbiter
// Revision            : 1.0
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_adr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic          dma_rvalid;
  logic [DW-1:0] dma_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter side
  modport master (
    input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
    input  dma_req, dma_we, dma_adr, dma_wdata,
    input  mem_rdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_adr, mem_wdata
  );

  // Requester / RAM environment side
  modport slave (
    output cpu_req, cpu_we, cpu_adr, cpu_wdata,
    output dma_req, dma_we, dma_adr, dma_wdata,
    output mem_rdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_adr, mem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_sat_counter.sv
// ============================================================================
// sat_counter : up-counter with synchronous clear, saturating at LIMIT
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int LIMIT = 4,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         inc,
  input  wire logic         clr,
  output logic      [W-1:0] cnt
);

  localparam logic [W-1:0] C_LIMIT = W'(LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != C_LIMIT)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one single-port RAM between the CPU and a DMA
//                    engine; CPU priority with DMA burst lock and anti-starve
// Revision         : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input wire logic           clk,
  input wire logic           reset,
  mem_port_arbiter_if.master bus
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [BW-1:0] C_MAX_BURST    = BW'(MAX_BURST);
  localparam logic [SW-1:0] C_STARVE_LIMIT = SW'(STARVE_LIMIT);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [BW-1:0] r_burst_cnt;
  logic [SW-1:0] r_starve_cnt;
  logic          w_dma_wins;
  logic          w_cpu_gnt;
  logic          w_dma_gnt;
  logic          w_mem_en;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_adr;
  logic [DW-1:0] w_mem_wdata;
  logic          r_rd_pending;
  logic          r_rd_owner;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grants are gated by reset so nothing reaches the RAM while it is held
  always_comb begin
    w_state_nxt = IDLE;
    w_cpu_gnt   = 1'b0;
    w_dma_gnt   = 1'b0;
    w_dma_wins  = ((r_state == DMA_OWN) && (r_burst_cnt < C_MAX_BURST)) ||
                  (r_starve_cnt == C_STARVE_LIMIT);
    if (reset) begin
      if (bus.cpu_req && bus.dma_req) begin
        w_dma_gnt = w_dma_wins;
        w_cpu_gnt = !w_dma_wins;
      end else begin
        w_cpu_gnt = bus.cpu_req;
        w_dma_gnt = bus.dma_req;
      end
    end
    if (w_cpu_gnt) begin
      w_state_nxt = CPU_OWN;
    end else if (w_dma_gnt) begin
      w_state_nxt = DMA_OWN;
    end
  end

  sat_counter #(.LIMIT(MAX_BURST), .W(BW)) u_burst_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (w_dma_gnt),
    .clr   (!w_dma_gnt),
    .cnt   (r_burst_cnt)
  );

  sat_counter #(.LIMIT(STARVE_LIMIT), .W(SW)) u_starve_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (bus.dma_req && !w_dma_gnt),
    .clr   (w_dma_gnt),
    .cnt   (r_starve_cnt)
  );

  // CPU fields stay on the RAM bus whenever DMA is not granted
  assign w_mem_en    = w_cpu_gnt || w_dma_gnt;
  assign w_mem_we    = w_mem_en && (w_dma_gnt ? bus.dma_we : bus.cpu_we);
  assign w_mem_adr   = w_dma_gnt ? bus.dma_adr : bus.cpu_adr;
  assign w_mem_wdata = w_dma_gnt ? bus.dma_wdata : bus.cpu_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_pending <= 1'b0;
      r_rd_owner   <= OWN_CPU;
    end else begin
      r_rd_pending <= w_mem_en && !w_mem_we;
      if (w_mem_en) begin
        r_rd_owner <= w_dma_gnt ? OWN_DMA : OWN_CPU;
      end
    end
  end

  assign bus.cpu_stall  = bus.cpu_req && !w_cpu_gnt;
  assign bus.dma_gnt    = w_dma_gnt;
  assign bus.mem_en     = w_mem_en;
  assign bus.mem_we     = w_mem_we;
  assign bus.mem_adr    = w_mem_adr;
  assign bus.mem_wdata  = w_mem_wdata;
  assign bus.cpu_rvalid = r_rd_pending && (r_rd_owner == OWN_CPU);
  assign bus.dma_rvalid = r_rd_pending && (r_rd_owner == OWN_DMA);
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.dma_rdata  = bus.mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed + random stimulus, reference model and
//                       read-return scoreboard for mem_port_arbiter
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int AW           = 32;
  localparam int DW           = 32;
  localparam int MAX_BURST    = 8;
  localparam int STARVE_LIMIT = 4;

  typedef struct {
    int          due;
    bit          owner;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_vec;
  int   n_fail;
  exp_t sb[$];

  logic [31:0] ram     [0:1023];
  logic [31:0] ref_mem [0:1023];

  int m_run;
  int m_wait;
  bit m_last_dma;
  bit last_cpu_stall;
  bit last_dma_gnt;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .AW           (AW),
    .DW           (DW),
    .MAX_BURST    (MAX_BURST),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    bus.cpu_req = r; bus.cpu_we = w; bus.cpu_adr = a; bus.cpu_wdata = d;
  endtask

  task automatic set_dma(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    bus.dma_req = r; bus.dma_we = w; bus.dma_adr = a; bus.dma_wdata = d;
  endtask

  // Cycle counter and the RAM itself (1-cycle read latency)
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      if (bus.mem_en) begin
        if (bus.mem_we) ram[bus.mem_adr[11:2]] = bus.mem_wdata;
        else            bus.mem_rdata = ram[bus.mem_adr[11:2]];
      end
      cyc++;
    end
  end

  // Reference model: arbitration rules written with plain run-length counts
  initial begin
    bit gc, gd, wins;
    m_run = 0; m_wait = 0; m_last_dma = 0;
    forever begin
      @(negedge clk);
      gc = 0; gd = 0;
      if (!reset) begin
        m_run = 0; m_wait = 0; m_last_dma = 0;
        sb.delete();
      end else begin
        wins = (m_last_dma && m_run < MAX_BURST) || (m_wait >= STARVE_LIMIT);
        gd = bus.dma_req && (!bus.cpu_req || wins);
        gc = bus.cpu_req && !gd;
      end
      chk("dma_gnt",   bus.dma_gnt,   gd);
      chk("cpu_stall", bus.cpu_stall, bus.cpu_req && !gc);
      chk("mem_en",    bus.mem_en,    gc || gd);
      if (gd) begin
        chk("dma_mem_we",  bus.mem_we,  bus.dma_we);
        chk("dma_mem_adr", bus.mem_adr, bus.dma_adr);
        if (bus.dma_we) begin
          chk("dma_mem_wdata", bus.mem_wdata, bus.dma_wdata);
          ref_mem[bus.dma_adr[11:2]] = bus.dma_wdata;
        end else begin
          sb.push_back('{due: cyc + 1, owner: 1'b1, data: ref_mem[bus.dma_adr[11:2]]});
        end
      end else if (gc) begin
        chk("cpu_mem_we",  bus.mem_we,  bus.cpu_we);
        chk("cpu_mem_adr", bus.mem_adr, bus.cpu_adr);
        if (bus.cpu_we) begin
          chk("cpu_mem_wdata", bus.mem_wdata, bus.cpu_wdata);
          ref_mem[bus.cpu_adr[11:2]] = bus.cpu_wdata;
        end else begin
          sb.push_back('{due: cyc + 1, owner: 1'b0, data: ref_mem[bus.cpu_adr[11:2]]});
        end
      end else begin
        chk("idle_mem_we",  bus.mem_we,  1'b0);
        chk("idle_mem_adr", bus.mem_adr, bus.cpu_adr);
      end
      if (reset) begin
        m_last_dma = gd;
        m_run      = gd ? m_run + 1 : 0;
        if (gd)               m_wait = 0;
        else if (bus.dma_req) m_wait = m_wait + 1;
      end
      last_cpu_stall = bus.cpu_req && !gc;
      last_dma_gnt   = gd;
    end
  end

  // Monitor: read returns compared against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_cpu_rvalid", bus.cpu_rvalid, 1'b0);
        chk("rst_dma_rvalid", bus.dma_rvalid, 1'b0);
        while (sb.size() > 0 && sb[0].due <= cyc) void'(sb.pop_front());
      end else if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("cpu_rvalid", bus.cpu_rvalid, e.owner == 1'b0);
        chk("dma_rvalid", bus.dma_rvalid, e.owner == 1'b1);
        if (e.owner) chk("dma_rdata", bus.dma_rdata, e.data);
        else         chk("cpu_rdata", bus.cpu_rdata, e.data);
      end else begin
        chk("spurious_cpu_rvalid", bus.cpu_rvalid, 1'b0);
        chk("spurious_dma_rvalid", bus.dma_rvalid, 1'b0);
      end
    end
  end

  initial begin
    n_vec = 0; n_fail = 0;
    for (int i = 0; i < 1024; i++) begin
      ram[i]     = init_val(32'(i) << 2);
      ref_mem[i] = init_val(32'(i) << 2);
    end
    ram[16]     = 32'hDEADBEEF;
    ref_mem[16] = 32'hDEADBEEF;
    bus.mem_rdata = '0;
    reset = 1'b0;
    set_cpu(1, 0, 32'h8, 0);
    set_dma(0, 0, 0, 0);

    // Reset hold with CPU requesting, then release
    step(); #2;
    chk("t1_rst_mem_en",    bus.mem_en,    1'b0);
    chk("t1_rst_cpu_stall", bus.cpu_stall, 1'b1);
    step();
    reset = 1'b1;
    #2;
    chk("t1_rel_mem_en",    bus.mem_en,    1'b1);
    chk("t1_rel_cpu_stall", bus.cpu_stall, 1'b0);

    // CPU read of 0x40
    step();
    set_cpu(1, 0, 32'h40, 0);
    #2;
    chk("t2_mem_adr", bus.mem_adr, 32'h40);
    chk("t2_mem_we",  bus.mem_we,  1'b0);
    step();
    set_cpu(0, 0, 0, 0);
    #2;
    chk("t2_cpu_rvalid", bus.cpu_rvalid, 1'b1);
    chk("t2_cpu_rdata",  bus.cpu_rdata,  32'hDEADBEEF);
    chk("t2_dma_rvalid", bus.dma_rvalid, 1'b0);

    // Lone DMA write
    step();
    set_dma(1, 1, 32'h100, 32'h12345678);
    #2;
    chk("t3_dma_gnt",   bus.dma_gnt,   1'b1);
    chk("t3_mem_we",    bus.mem_we,    1'b1);
    chk("t3_mem_wdata", bus.mem_wdata, 32'h12345678);
    step();
    set_dma(0, 0, 0, 0);
    #2;
    chk("t3_dma_rvalid", bus.dma_rvalid, 1'b0);

    // Continuous contention from IDLE: 4 CPU beats then an 8-beat DMA burst
    step();
    for (int k = 0; k < 24; k++) begin
      step();
      set_cpu(1, 0, 32'(k) << 2, 0);
      set_dma(1, 0, 32'h200 + (32'(k) << 2), 0);
      #2;
      chk("t4_burst_pattern", bus.dma_gnt, (k % 12) >= 4);
    end

    // Alternating reads
    step();
    set_cpu(1, 0, 32'h10, 0);
    set_dma(0, 0, 0, 0);
    step();
    set_cpu(0, 0, 0, 0);
    set_dma(1, 0, 32'h20, 0);
    #2;
    chk("t5_c1_cpu_rvalid", bus.cpu_rvalid, 1'b1);
    chk("t5_c1_dma_rvalid", bus.dma_rvalid, 1'b0);
    step();
    set_dma(0, 0, 0, 0);
    #2;
    chk("t5_c2_dma_rvalid", bus.dma_rvalid, 1'b1);
    chk("t5_c2_dma_rdata",  bus.dma_rdata,  init_val(32'h20));

    // Contested CPU read, then reset lands on the return cycle
    step();
    step();
    set_cpu(1, 0, 32'h30, 0);
    set_dma(1, 0, 32'h34, 0);
    step();
    reset = 1'b0;
    set_cpu(0, 0, 0, 0);
    set_dma(0, 0, 0, 0);
    #2;
    chk("t6_cpu_rvalid", bus.cpu_rvalid, 1'b0);
    step();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      set_cpu(1, 0, 32'h50, 0);
      set_dma(1, 0, 32'h54, 0);
      #2;
      chk("t6_post_rst_gnt", bus.dma_gnt, k == 4);
    end

    // Random traffic honouring the hold-until-granted rules
    for (int n = 0; n < 600; n++) begin
      step();
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 149) == 0) reset = 1'b0;
      if (!(bus.cpu_req && last_cpu_stall))
        set_cpu($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                32'($urandom_range(0, 1023)) << 2, $urandom);
      if (!(bus.dma_req && !last_dma_gnt))
        set_dma($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                32'($urandom_range(0, 1023)) << 2, $urandom);
    end

    step();
    reset = 1'b1;
    set_cpu(0, 0, 0, 0);
    set_dma(0, 0, 0, 0);
    step();
    step();
    #2;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
